// File: rtl/exp_fsmd_lcd_top.sv
// Exponent FSMD with an HD44780 character LCD front end.
// The FSMD computes a**n (mod 2^16) by repeated multiplication. When the
// result becomes valid, the LCD controller converts it to five decimal digits
// and writes it to a 16x2 display over an 8-bit write-only bus.
`timescale 1ns/1ps
module exp_fsmd_lcd_top #(
  parameter int EN_CYCLES = 12,
  parameter int CMD_WAIT  = 2000,
  parameter int CLR_WAIT  = 100000,
  parameter int PWR_WAIT  = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_i,
  input  logic [7:0]  n_i,
  input  logic [7:0]  a_i,
  output logic [15:0] output_reg,
  output logic        sig_done,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_EN,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        LCD_OVER
);

  typedef enum logic [1:0] {
    F_IDLE,
    F_INIT,
    F_LOOP,
    F_DONE
  } fsmd_state_t;

  typedef enum logic [2:0] {
    L_IDLE,
    L_PWRUP,
    L_CONVERT,
    L_WRITE,
    L_EN_HI,
    L_WAIT,
    L_OVER
  } lcd_state_t;

  fsmd_state_t f_state, f_next;
  lcd_state_t  l_state, l_next;

  logic [7:0]  a_reg;
  logic [7:0]  cnt;
  logic [15:0] res;

  logic        sig_done_q;
  logic        start;
  logic        lcd_busy;
  logic        go_accept;
  logic        pwr_done;

  logic [31:0] timer;
  logic [31:0] wait_lim;
  logic [3:0]  idx;
  logic [3:0]  next_idx;
  logic [3:0]  bit_cnt;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;

  // The display is write-only and always powered with the backlight on.
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

  // A new result kicks off the display sequence on the rising edge of sig_done.
  // That pending edge counts as busy so a go in the gap cannot slip in.
  assign start     = sig_done & ~sig_done_q;
  assign lcd_busy  = !pwr_done || start ||
                     !((l_state == L_IDLE) || (l_state == L_OVER));
  assign go_accept = go_i && !lcd_busy &&
                     ((f_state == F_IDLE) || (f_state == F_DONE));

  assign next_idx = idx + 4'd1;
  assign wait_lim = (idx == 4'd2) ? 32'(CLR_WAIT) : 32'(CMD_WAIT);

  // Byte for each step of the write sequence: five set-up commands, then digits.
  function automatic logic [7:0] lcd_byte(input logic [3:0] i, input logic [19:0] digits);
    case (i)
      4'd0:    lcd_byte = 8'h38;
      4'd1:    lcd_byte = 8'h0C;
      4'd2:    lcd_byte = 8'h01;
      4'd3:    lcd_byte = 8'h06;
      4'd4:    lcd_byte = 8'h80;
      4'd5:    lcd_byte = 8'h30 + {4'h0, digits[19:16]};
      4'd6:    lcd_byte = 8'h30 + {4'h0, digits[15:12]};
      4'd7:    lcd_byte = 8'h30 + {4'h0, digits[11:8]};
      4'd8:    lcd_byte = 8'h30 + {4'h0, digits[7:4]};
      4'd9:    lcd_byte = 8'h30 + {4'h0, digits[3:0]};
      default: lcd_byte = 8'h20;
    endcase
  endfunction

  // FSMD state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) f_state <= F_IDLE;
    else     f_state <= f_next;
  end

  // FSMD next-state: accept a start, one init cycle, then loop until the count runs out.
  always_comb begin
    f_next = f_state;
    case (f_state)
      F_IDLE, F_DONE: if (go_accept) f_next = F_INIT;
      F_INIT:         f_next = F_LOOP;
      F_LOOP:         if (cnt == 8'd0) f_next = F_DONE;
      default:        f_next = F_IDLE;
    endcase
  end

  // FSMD datapath: operand latch, running product, down-counter and result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= 8'd0;
      cnt        <= 8'd0;
      res        <= 16'd0;
      output_reg <= 16'd0;
      sig_done   <= 1'b0;
    end else begin
      case (f_state)
        F_IDLE, F_DONE: begin
          if (go_accept) begin
            a_reg    <= a_i;
            cnt      <= n_i;
            res      <= 16'd1;
            sig_done <= 1'b0;
          end else if (f_state == F_DONE) begin
            sig_done <= 1'b1;
          end
        end
        F_LOOP: begin
          if (cnt != 8'd0) begin
            res <= res * {8'h00, a_reg};
            cnt <= cnt - 8'd1;
          end else begin
            output_reg <= res;
          end
        end
        default: ;
      endcase
    end
  end

  // One double-dabble correction: add 3 to every BCD digit of 5 or more before shifting.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // LCD controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) l_state <= L_IDLE;
    else     l_state <= l_next;
  end

  // LCD next-state: power-up delay once, then convert, and cycle write/strobe/wait per byte.
  always_comb begin
    l_next = l_state;
    case (l_state)
      L_IDLE: begin
        if (!pwr_done)  l_next = L_PWRUP;
        else if (start) l_next = L_CONVERT;
      end
      L_PWRUP:   if (timer == 32'(PWR_WAIT - 1)) l_next = L_IDLE;
      L_OVER:    if (start) l_next = L_CONVERT;
      L_CONVERT: if (bit_cnt == 4'd15) l_next = L_WRITE;
      L_WRITE:   l_next = L_EN_HI;
      L_EN_HI:   if (timer == 32'(EN_CYCLES - 1)) l_next = L_WAIT;
      L_WAIT: begin
        if (timer == wait_lim - 32'd1) l_next = (idx == 4'd9) ? L_OVER : L_WRITE;
      end
      default:   l_next = L_IDLE;
    endcase
  end

  // LCD datapath: delay timer, BCD shifter, bus drivers and the sequence-complete flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer      <= 32'd0;
      idx        <= 4'd0;
      bit_cnt    <= 4'd0;
      bin        <= 16'd0;
      bcd        <= 20'd0;
      pwr_done   <= 1'b0;
      sig_done_q <= 1'b0;
      LCD_DATA   <= 8'd0;
      LCD_RS     <= 1'b0;
      LCD_EN     <= 1'b0;
      LCD_OVER   <= 1'b0;
    end else begin
      sig_done_q <= sig_done;

      if (l_next != l_state) timer <= 32'd0;
      else if ((l_state == L_PWRUP) || (l_state == L_EN_HI) || (l_state == L_WAIT))
        timer <= timer + 32'd1;

      case (l_state)
        L_PWRUP: if (l_next == L_IDLE) pwr_done <= 1'b1;
        L_IDLE, L_OVER: begin
          if (l_next == L_CONVERT) begin
            bin     <= output_reg;
            bcd     <= 20'd0;
            bit_cnt <= 4'd0;
          end
        end
        L_CONVERT: begin
          bcd     <= {bcd_adj[18:0], bin[15]};
          bin     <= {bin[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (l_next == L_WRITE) begin
            idx      <= 4'd0;
            LCD_DATA <= lcd_byte(4'd0, bcd);
            LCD_RS   <= 1'b0;
          end
        end
        L_WAIT: begin
          if (l_next == L_WRITE) begin
            idx      <= next_idx;
            LCD_DATA <= lcd_byte(next_idx, bcd);
            LCD_RS   <= (next_idx >= 4'd5);
          end
        end
        default: ;
      endcase

      LCD_EN <= (l_next == L_EN_HI);

      if (go_accept) LCD_OVER <= 1'b0;
      else if ((l_state == L_WAIT) && (l_next == L_OVER)) LCD_OVER <= 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_fsmd_lcd_top.sv
// Scoreboard bench for exp_fsmd_lcd_top: stimulus pushes expected results and
// LCD bus writes; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_exp_fsmd_lcd_top;

  localparam int EN_CYCLES = 3;
  localparam int CMD_WAIT  = 5;
  localparam int CLR_WAIT  = 9;
  localparam int PWR_WAIT  = 20;

  logic        clk;
  logic        rst;
  logic        go_i;
  logic [7:0]  n_i;
  logic [7:0]  a_i;
  logic [15:0] output_reg;
  logic        sig_done;
  logic [7:0]  LCD_DATA;
  logic        LCD_EN;
  logic        LCD_RS;
  logic        LCD_RW;
  logic        LCD_ON;
  logic        LCD_BLON;
  logic        LCD_OVER;

  int vectors = 0;
  int miscompares = 0;
  int cycle_count = 0;
  int go_cycle = 0;
  logic [7:0] last_char = 8'h00;

  logic [15:0] exp_res[$];
  logic [8:0]  exp_lcd[$];

  exp_fsmd_lcd_top #(
    .EN_CYCLES(EN_CYCLES),
    .CMD_WAIT (CMD_WAIT),
    .CLR_WAIT (CLR_WAIT),
    .PWR_WAIT (PWR_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go_i      (go_i),
    .n_i       (n_i),
    .a_i       (a_i),
    .output_reg(output_reg),
    .sig_done  (sig_done),
    .LCD_DATA  (LCD_DATA),
    .LCD_EN    (LCD_EN),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_ON    (LCD_ON),
    .LCD_BLON  (LCD_BLON),
    .LCD_OVER  (LCD_OVER)
  );

  // 100 MHz bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain modular exponentiation.
  function automatic logic [15:0] refPow(input int unsigned a, input int unsigned n);
    int unsigned r = 1;
    for (int k = 0; k < int'(n); k++) r = (r * a) % 65536;
    return 16'(r);
  endfunction

  // Expected LCD bus writes for a result: init commands, then five decimal digits.
  task automatic pushLcd(input logic [15:0] value);
    int unsigned v = value;
    int unsigned d[5];
    exp_lcd.push_back({1'b0, 8'h38});
    exp_lcd.push_back({1'b0, 8'h0C});
    exp_lcd.push_back({1'b0, 8'h01});
    exp_lcd.push_back({1'b0, 8'h06});
    exp_lcd.push_back({1'b0, 8'h80});
    for (int k = 4; k >= 0; k--) begin
      d[k] = v % 10;
      v = v / 10;
    end
    for (int k = 0; k < 5; k++) exp_lcd.push_back({1'b1, 8'(8'h30 + d[k])});
    last_char = 8'(8'h30 + d[4]);
  endtask

  task automatic pulseGo(input logic [7:0] a, input logic [7:0] n);
    @(negedge clk);
    a_i  = a;
    n_i  = n;
    go_i = 1'b1;
    @(negedge clk);
    go_i = 1'b0;
  endtask

  // Issue an accepted operation and record what the DUT should produce.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] n);
    logic [15:0] r;
    r = refPow(a, n);
    exp_res.push_back(r);
    pushLcd(r);
    pulseGo(a, n);
    go_cycle = cycle_count;
  endtask

  task automatic waitDone(input logic [7:0] n);
    int guard = 0;
    while (!sig_done && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("sig_done_seen", {31'd0, sig_done}, 32'd1);
    checkOutput("latency", 32'(cycle_count - go_cycle), 32'(int'(n) + 3));
  endtask

  task automatic waitOver();
    int guard = 0;
    while (!LCD_OVER && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("lcd_over", {31'd0, LCD_OVER}, 32'd1);
    checkOutput("lcd_queue_drained", 32'(exp_lcd.size()), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("lcd_data_held", {24'd0, LCD_DATA}, {24'd0, last_char});
    checkOutput("lcd_over_held", {31'd0, LCD_OVER}, 32'd1);
  endtask

  task automatic waitEnRise();
    int guard = 0;
    while (!LCD_EN && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("lcd_en_seen", {31'd0, LCD_EN}, 32'd1);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_output_reg", {16'd0, output_reg}, 32'd0);
    checkOutput("rst_sig_done", {31'd0, sig_done}, 32'd0);
    checkOutput("rst_lcd_en", {31'd0, LCD_EN}, 32'd0);
    checkOutput("rst_lcd_rs", {31'd0, LCD_RS}, 32'd0);
    checkOutput("rst_lcd_rw", {31'd0, LCD_RW}, 32'd0);
    checkOutput("rst_lcd_over", {31'd0, LCD_OVER}, 32'd0);
    checkOutput("rst_lcd_data", {24'd0, LCD_DATA}, 32'd0);
    checkOutput("rst_lcd_on", {31'd0, LCD_ON}, 32'd1);
    checkOutput("rst_lcd_blon", {31'd0, LCD_BLON}, 32'd1);
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1 checkResetValues();
    exp_res.delete();
    exp_lcd.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (PWR_WAIT + 5) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on result-valid and on every LCD strobe.
  logic       prev_en = 1'b0;
  logic       prev_done = 1'b0;
  logic       prev_over = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         en_width = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_en   = 1'b0;
      prev_done = 1'b0;
      prev_over = 1'b0;
      en_width  = 0;
    end else begin
      if (sig_done && !prev_done) begin
        if (exp_res.size() == 0) checkOutput("result_extra", 32'd0, 32'd1);
        else checkOutput("result", {16'd0, output_reg}, {16'd0, exp_res.pop_front()});
      end
      if (LCD_EN && !prev_en) begin
        if (exp_lcd.size() == 0) checkOutput("lcd_write_extra", 32'd0, 32'd1);
        else checkOutput("lcd_write", {23'd0, LCD_RS, LCD_DATA}, {23'd0, exp_lcd.pop_front()});
        checkOutput("lcd_setup", {23'd0, prev_rs, prev_data}, {23'd0, LCD_RS, LCD_DATA});
      end
      if (LCD_EN) en_width++;
      if (!LCD_EN && prev_en) begin
        checkOutput("lcd_en_width", 32'(en_width), 32'(EN_CYCLES));
        en_width = 0;
      end
      if (LCD_OVER && !prev_over)
        checkOutput("lcd_over_after_all", 32'(exp_lcd.size()), 32'd0);
      prev_en   = LCD_EN;
      prev_done = sig_done;
      prev_over = LCD_OVER;
    end
    prev_rs   = LCD_RS;
    prev_data = LCD_DATA;
  end

  initial begin
    logic [7:0] ra, rn;
    rst  = 1'b1;
    go_i = 1'b0;
    a_i  = 8'd0;
    n_i  = 8'd0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    repeat (PWR_WAIT + 5) @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(8'd2, 8'd8);   waitDone(8'd8); waitOver();
    applyStimulus(8'd3, 8'd4);   waitDone(8'd4); waitOver();
    applyStimulus(8'd7, 8'd0);   waitDone(8'd0); waitOver();
    applyStimulus(8'd0, 8'd5);   waitDone(8'd5); waitOver();
    applyStimulus(8'd255, 8'd3); waitDone(8'd3); waitOver();

    $display("[TB] go ignored while busy");
    applyStimulus(8'd5, 8'd6);
    repeat (3) @(negedge clk);
    pulseGo(8'd9, 8'd2);
    waitDone(8'd6);
    waitEnRise();
    pulseGo(8'd1, 8'd1);
    repeat (2) @(negedge clk);
    checkOutput("busy_sig_done_held", {31'd0, sig_done}, 32'd1);
    checkOutput("busy_result_kept", {16'd0, output_reg}, 32'd15625);
    waitOver();

    $display("[TB] reset mid-loop");
    applyStimulus(8'd3, 8'd9);
    repeat (4) @(negedge clk);
    doReset();
    applyStimulus(8'd6, 8'd2); waitDone(8'd2); waitOver();

    $display("[TB] reset mid-LCD write");
    applyStimulus(8'd4, 8'd3);
    waitDone(8'd3);
    waitEnRise();
    doReset();
    applyStimulus(8'd11, 8'd3); waitDone(8'd3); waitOver();

    $display("[TB] random cases");
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rn = 8'($urandom_range(0, 40));
      applyStimulus(ra, rn);
      waitDone(rn);
      waitOver();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
